// File: rtl/rf_writeback.sv
// RV32I register file with write-back source select and load extraction.
// Zero-latency reads with same-cycle write-through bypass.
module rf_writeback #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rf_we,
  input  logic [1:0]        wb_sel,
  input  logic [2:0]        ld_type,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [DATA_W-1:0] dram_rd,
  input  logic [DATA_W-1:0] pc4,
  input  logic [DATA_W-1:0] ext,
  input  logic [4:0]        wR,
  input  logic [4:0]        rR1,
  input  logic [4:0]        rR2,
  output logic [DATA_W-1:0] rD1,
  output logic [DATA_W-1:0] rD2,
  output logic [DATA_W-1:0] wD,
  output logic [31:0]       wb_cnt
);

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  logic [DATA_W-1:0] rf_q [REG_NUM];
  logic [DATA_W-1:0] rf_d;
  logic [31:0]       cnt_q;
  logic [31:0]       cnt_d;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;
  logic              wr_go;

  always_comb begin
    ld_byte = dram_rd[7:0];
    case (ld_off)
      2'd0:    ld_byte = dram_rd[7:0];
      2'd1:    ld_byte = dram_rd[15:8];
      2'd2:    ld_byte = dram_rd[23:16];
      default: ld_byte = dram_rd[31:24];
    endcase
  end

  // ld_off[0] is ignored for halfwords
  assign ld_half = ld_off[1] ? dram_rd[31:16]
                             : dram_rd[15:0];

  always_comb begin
    ld_data = dram_rd;
    case (ld_type)
      LD_B:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      LD_BU: ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
      LD_H:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
      LD_HU: ld_data = {{(DATA_W-16){1'b0}}, ld_half};
      LD_W:  ld_data = dram_rd;
      default: ld_data = dram_rd;
    endcase
  end

  always_comb begin
    wD = alu_c;
    case (wb_sel)
      WB_ALU: wD = alu_c;
      WB_MEM: wD = ld_data;
      WB_PC4: wD = pc4;
      WB_IMM: wD = ext;
      default: wD = alu_c;
    endcase
  end

  assign wr_go = rf_we && (wR != 5'd0);
  assign rf_d  = wD;
  assign cnt_d = cnt_q + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        rf_q[i] <= '0;
      end
      cnt_q <= '0;
    end else if (wr_go) begin
      rf_q[wR] <= rf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Reset forces both ports to zero, overriding the bypass
  always_comb begin
    rD1 = '0;
    if (!rst && rR1 != 5'd0) begin
      if (rf_we && wR == rR1) rD1 = wD;
      else                    rD1 = rf_q[rR1];
    end
  end

  always_comb begin
    rD2 = '0;
    if (!rst && rR2 != 5'd0) begin
      if (rf_we && wR == rR2) rD2 = wD;
      else                    rD2 = rf_q[rR2];
    end
  end

  assign wb_cnt = cnt_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: directed cases plus randomized traffic
// checked against an array-based register-file model.
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [2:0]  ld_type;
  logic [1:0]  ld_off;
  logic [31:0] alu_c, dram_rd, pc4, ext;
  logic [4:0]  wR, rR1, rR2;
  logic [31:0] rD1, rD2, wD, wb_cnt;

  rf_writeback dut (
    .clk(clk), .rst(rst), .rf_we(rf_we),
    .wb_sel(wb_sel), .ld_type(ld_type),
    .ld_off(ld_off), .alu_c(alu_c),
    .dram_rd(dram_rd), .pc4(pc4), .ext(ext),
    .wR(wR), .rR1(rR1), .rR2(rR2),
    .rD1(rD1), .rD2(rD2), .wD(wD),
    .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_cnt = 32'd0;
  endtask

  function automatic logic [31:0] m_load();
    int unsigned b, h;
    b = (dram_rd >> (8 * ld_off)) & 32'hFF;
    h = (dram_rd >> (16 * ld_off[1])) & 32'hFFFF;
    case (ld_type)
      3'd0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4: return b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5: return h;
      default: return dram_rd;
    endcase
  endfunction

  function automatic logic [31:0] m_wd();
    case (wb_sel)
      2'd0: return alu_c;
      2'd1: return m_load();
      2'd2: return pc4;
      default: return ext;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (rst || a == 0) return 32'd0;
    if (rf_we && wR == a) return m_wd();
    return m_rf[a];
  endfunction

  task automatic check_comb(input string tag);
    #1;
    chk({tag, ".rD1"}, rD1, m_rd(rR1));
    chk({tag, ".rD2"}, rD2, m_rd(rR2));
    chk({tag, ".wD"}, wD, m_wd());
    chk({tag, ".cnt"}, wb_cnt, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst && rf_we && wR != 0) begin
      m_rf[wR] = m_wd();
      m_cnt    = m_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  logic [2:0]  lt_tab [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [1:0]  lo_tab [5] = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0] le_tab [5] = '{32'hFFFF_FF80, 32'h0000_007F,
                              32'hFFFF_80FF, 32'h0000_80FF,
                              32'h80FF_7F01};

  initial begin
    rst = 1'b1; rf_we = 0; wb_sel = 0; ld_type = 0;
    ld_off = 0; alu_c = 0; dram_rd = 0; pc4 = 0;
    ext = 0; wR = 0; rR1 = 5; rR2 = 0;
    m_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst.rD1", rD1, 32'd0);
    chk("rst.cnt", wb_cnt, 32'd0);
    rst = 1'b0;

    // preload x5, then async reset mid-cycle
    rf_we = 1; wR = 5; wb_sel = 2'b11; ext = 32'h1234_5678;
    check_comb("pre");
    tick();
    rf_we = 0;
    check_comb("pre2");
    chk("pre.x5", rD1, 32'h1234_5678);
    rf_we = 1; ext = 32'hAAAA_5555;
    #1 rst = 1'b1;
    m_reset();
    #1;
    chk("arst.rD1", rD1, 32'd0);
    chk("arst.cnt", wb_cnt, 32'd0);
    tick();
    chk("rsthold.cnt", wb_cnt, 32'd0);
    rst = 1'b0; rf_we = 0;
    check_comb("rel");
    chk("rel.x5", rD1, 32'd0);

    // x0 writes are dropped
    rf_we = 1; wR = 0; wb_sel = 2'b11;
    ext = 32'hDEAD_BEEF; rR1 = 0; rR2 = 0;
    check_comb("x0a");
    chk("x0.wD", wD, 32'hDEAD_BEEF);
    tick();
    rf_we = 0;
    check_comb("x0b");
    chk("x0.cnt", wb_cnt, 32'd0);

    // load extraction
    wb_sel = 2'b01; dram_rd = 32'h80FF_7F01;
    for (int i = 0; i < 5; i++) begin
      ld_type = lt_tab[i]; ld_off = lo_tab[i];
      check_comb("ld");
      chk("ld.const", wD, le_tab[i]);
    end

    // bypass on both ports
    rf_we = 1; wR = 7; wb_sel = 2'b10;
    pc4 = 32'h0000_0104; rR1 = 7; rR2 = 7;
    check_comb("byp");
    chk("byp.rD1", rD1, 32'h0000_0104);
    chk("byp.rD2", rD2, 32'h0000_0104);
    tick();
    rf_we = 0;
    check_comb("byp2");
    chk("byp.x7", rD1, 32'h0000_0104);

    // sources into x1..x3
    alu_c = 1; pc4 = 2; ext = 3; ld_type = 3'd0;
    for (int i = 1; i <= 3; i++) begin
      rf_we = 1; wR = 5'(i);
      wb_sel = (i == 1) ? 2'b00 : (i == 2) ? 2'b10 : 2'b11;
      check_comb("src");
      chk("src.wD", wD, 32'(i));
      tick();
    end
    rf_we = 0;
    for (int i = 1; i <= 3; i++) begin
      rR1 = 5'(i);
      check_comb("rb");
      chk("rb.x", rD1, 32'(i));
    end
    chk("src.cnt", wb_cnt, 32'd4);

    // counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    chk("wrap.pre", wb_cnt, 32'hFFFF_FFFF);
    rf_we = 1; wR = 9; wb_sel = 2'b00; alu_c = 32'h99;
    tick();
    rf_we = 0;
    chk("wrap.cnt", wb_cnt, 32'd0);
    rR1 = 9;
    check_comb("wrap2");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rf_we   = ($urandom_range(0, 3) != 0);
      wb_sel  = 2'($urandom_range(0, 3));
      ld_type = 3'($urandom_range(0, 7));
      ld_off  = 2'($urandom_range(0, 3));
      alu_c   = $urandom;
      dram_rd = $urandom;
      pc4     = $urandom;
      ext     = $urandom;
      wR      = 5'($urandom_range(0, 31));
      rR1 = ($urandom_range(0, 3) == 0) ? wR
                                        : 5'($urandom_range(0, 31));
      rR2 = ($urandom_range(0, 3) == 0) ? wR
                                        : 5'($urandom_range(0, 31));
      check_comb("rnd");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
